// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the hard-wired zero register index and the memory-wait counter width.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_e;

    localparam logic [4:0]  ZERO_REG   = 5'd0;
    localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/load_use_detector.sv
// load_use_detector
// Combinational load-use comparator. Flags when the load in EX writes a
// register that the instruction in ID reads. Writes to the zero register
// never create a dependency. Shared with the forwarding unit.
//
// Ports:
//   in_ID_EX_MemRead  instruction in EX is a load
//   in_ID_EX_Rt       destination register of that load
//   in_IF_ID_Rs       rs field of the instruction in ID
//   in_IF_ID_Rt       rt field of the instruction in ID
//   out_LoadUse       load-use hazard present
module load_use_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic       in_ID_EX_MemRead,
    input  logic [4:0] in_ID_EX_Rt,
    input  logic [4:0] in_IF_ID_Rs,
    input  logic [4:0] in_IF_ID_Rt,
    output logic       out_LoadUse
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match  = (in_ID_EX_Rt == in_IF_ID_Rs);
    assign w_rt_match  = (in_ID_EX_Rt == in_IF_ID_Rt);
    assign out_LoadUse = in_ID_EX_MemRead && (in_ID_EX_Rt != ZERO_REG) &&
                         (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Central stall/flush sequencer for the 5-stage pipeline. Each cycle decides
// whether the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers capture, hold or
// take a bubble. Handles load-use hazards, taken branches/jumps and
// multi-cycle data-memory accesses, with a watchdog that halts the pipeline
// when a memory access never completes. State advances on the falling edge,
// in step with the pipeline registers; control outputs are combinational.
//
// Optional feature macro: HAZARD_STATS_EN adds saturating stall/flush counters.
//
// Ports:
//   clk                pipeline clock (falling-edge state update)
//   reset              asynchronous active-low reset
//   in_IF_ID_Rs/Rt     source fields of the instruction in ID
//   in_ID_EX_MemRead   instruction in EX is a load
//   in_ID_EX_Rt        destination of the load in EX
//   in_Jump            jump decoded in ID
//   in_BranchTaken     branch resolved taken in EX
//   in_MemAccess       load/store in MEM
//   in_MemReady        data memory completes the access this cycle
//   out_PCWrite        PC capture enable
//   out_IF_ID_Write    IF/ID capture enable
//   out_IF_ID_Flush    IF/ID loads a NOP
//   out_ID_EX_Flush    ID/EX control bits cleared
//   out_EX_MEM_Write   EX/MEM capture enable
//   out_MEM_WB_Bubble  MEM/WB loads RegWrite=0
//   out_MemTimeout     sticky watchdog flag
//   out_StallCount     cycles with PCWrite=0 (HAZARD_STATS_EN only)
//   out_FlushCount     cycles with IF_ID_Flush=1 (HAZARD_STATS_EN only)
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  in_IF_ID_Rs,
    input  logic [4:0]  in_IF_ID_Rt,
    input  logic        in_ID_EX_MemRead,
    input  logic [4:0]  in_ID_EX_Rt,
    input  logic        in_Jump,
    input  logic        in_BranchTaken,
    input  logic        in_MemAccess,
    input  logic        in_MemReady,
    output logic        out_PCWrite,
    output logic        out_IF_ID_Write,
    output logic        out_IF_ID_Flush,
    output logic        out_ID_EX_Flush,
    output logic        out_EX_MEM_Write,
    output logic        out_MEM_WB_Bubble,
    output logic        out_MemTimeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] out_StallCount,
    output logic [31:0] out_FlushCount
`endif
);

    ctrl_state_e           r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  w_load_use;
    logic                  w_mem_stall;

    load_use_detector u_load_use_detector (
        .in_ID_EX_MemRead (in_ID_EX_MemRead),
        .in_ID_EX_Rt      (in_ID_EX_Rt),
        .in_IF_ID_Rs      (in_IF_ID_Rs),
        .in_IF_ID_Rt      (in_IF_ID_Rt),
        .out_LoadUse      (w_load_use)
    );

    assign w_mem_stall = in_MemAccess && !in_MemReady;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WAIT_CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!w_mem_stall) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WAIT_CNT_W'(MEM_WAIT_MAX)) begin
                        r_state <= HALT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Priority decode. Reset is folded in so outputs take their reset values
    // while reset is low regardless of the other inputs.
    always_comb begin
        out_PCWrite       = 1'b1;
        out_IF_ID_Write   = 1'b1;
        out_IF_ID_Flush   = 1'b0;
        out_ID_EX_Flush   = 1'b0;
        out_EX_MEM_Write  = 1'b1;
        out_MEM_WB_Bubble = 1'b0;
        out_MemTimeout    = 1'b0;
        if (!reset) begin
            // keep defaults
        end else if (r_state == HALT) begin
            out_PCWrite       = 1'b0;
            out_IF_ID_Write   = 1'b0;
            out_EX_MEM_Write  = 1'b0;
            out_MEM_WB_Bubble = 1'b1;
            out_MemTimeout    = 1'b1;
        end else if (w_mem_stall) begin
            // ID/EX holds through its own stall path, so no flush here.
            out_PCWrite       = 1'b0;
            out_IF_ID_Write   = 1'b0;
            out_EX_MEM_Write  = 1'b0;
            out_MEM_WB_Bubble = 1'b1;
        end else if (in_BranchTaken) begin
            out_IF_ID_Flush = 1'b1;
            out_ID_EX_Flush = 1'b1;
        end else if (w_load_use) begin
            out_PCWrite     = 1'b0;
            out_IF_ID_Write = 1'b0;
            out_ID_EX_Flush = 1'b1;
        end else if (in_Jump) begin
            out_IF_ID_Flush = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!out_PCWrite && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (out_IF_ID_Flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign out_StallCount = r_stall_cnt;
    assign out_FlushCount = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller (MEM_WAIT_MAX = 4).
// Stimulus pushes hand-computed expected control vectors into a queue; a
// monitor samples the DUT ahead of each falling edge and compares.
// Vector bit order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
//                    EX_MEM_Write, MEM_WB_Bubble, MemTimeout}
module tb_pipeline_hazard_controller;

    localparam logic [6:0] DEF = 7'b1100100;
    localparam logic [6:0] LU  = 7'b0001100;
    localparam logic [6:0] BR  = 7'b1111100;
    localparam logic [6:0] JMP = 7'b1110100;
    localparam logic [6:0] MS  = 7'b0000010;
    localparam logic [6:0] HLT = 7'b0000011;

    logic       clk;
    logic       reset;
    logic [4:0] rs, rt, ex_rt;
    logic       mem_read, jump, br_taken, mem_acc, mem_rdy;
    logic       pcw, ifidw, ifidf, idexf, exmemw, bubble, timeout;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int fails  = 0;
    int step_id = 0;
    logic [6:0] exp_q[$];
    int         id_q[$];

    pipeline_hazard_controller #(.MEM_WAIT_MAX(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_IF_ID_Rs       (rs),
        .in_IF_ID_Rt       (rt),
        .in_ID_EX_MemRead  (mem_read),
        .in_ID_EX_Rt       (ex_rt),
        .in_Jump           (jump),
        .in_BranchTaken    (br_taken),
        .in_MemAccess      (mem_acc),
        .in_MemReady       (mem_rdy),
        .out_PCWrite       (pcw),
        .out_IF_ID_Write   (ifidw),
        .out_IF_ID_Flush   (ifidf),
        .out_ID_EX_Flush   (idexf),
        .out_EX_MEM_Write  (exmemw),
        .out_MEM_WB_Bubble (bubble),
        .out_MemTimeout    (timeout)
`ifdef HAZARD_STATS_EN
        ,
        .out_StallCount    (stall_cnt),
        .out_FlushCount    (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Inputs change 1 time unit after the rising edge; the falling edge that
    // updates state comes 4 units later.
    task automatic step(input logic rst, input logic mr, input logic [4:0] e_rt,
                        input logic [4:0] s_rs, input logic [4:0] s_rt, input logic j,
                        input logic b, input logic ma, input logic mrd,
                        input logic [6:0] exp_v);
        @(posedge clk);
        #1;
        reset    = rst;
        mem_read = mr;
        ex_rt    = e_rt;
        rs       = s_rs;
        rt       = s_rt;
        jump     = j;
        br_taken = b;
        mem_acc  = ma;
        mem_rdy  = mrd;
        exp_q.push_back(exp_v);
        id_q.push_back(step_id);
        step_id++;
    endtask

    // Monitor: samples 3 units after the rising edge, before the falling edge.
    initial begin
        logic [6:0] got;
        logic [6:0] e;
        int         id;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                id  = id_q.pop_front();
                got = {pcw, ifidw, ifidf, idexf, exmemw, bubble, timeout};
                checks++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL ctrl_step%0d: got %b, expected %b", id, got, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wait_cycles;
        reset = 1'b0; mem_read = 1'b0; ex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
        jump = 1'b0; br_taken = 1'b0; mem_acc = 1'b0; mem_rdy = 1'b0;

        //   rst mr  ert    rs     rt     j  b  ma mrd exp
        step(0, 1, 5'd8, 5'd8, 5'd0, 1, 1, 1, 0, DEF); // reset dominates inputs
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, DEF);
        step(1, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, LU);  // load-use on rs
        step(1, 0, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, DEF); // bubble cleared MemRead
        step(1, 1, 5'd9, 5'd4, 5'd9, 0, 0, 0, 0, LU);  // load-use on rt
        step(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, DEF); // zero register: no stall
        step(1, 1, 5'd8, 5'd5, 5'd6, 0, 0, 0, 0, DEF); // no match
        step(1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0, BR);  // branch beats load-use
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, BR);
        step(1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, BR);  // branch beats jump
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 32'd2) begin
            fails++;
            $display("FAIL stall_count: got %0d, expected 2", stall_cnt);
        end
        checks++;
        if (flush_cnt !== 32'd3) begin
            fails++;
            $display("FAIL flush_count: got %0d, expected 3", flush_cnt);
        end
`endif
        step(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, JMP);
        step(1, 1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0, LU);  // load-use beats jump
        // Three-cycle memory latency; branch and load-use requests ignored.
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, MS);
        step(1, 1, 5'd7, 5'd7, 5'd0, 0, 0, 1, 0, MS);
        step(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, MS);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, DEF); // ready: back to RUN
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, BR);  // branch re-evaluated
        // Access withdrawn mid-wait.
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MS);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, DEF);
        // Four stalls then ready must not halt (counter restarted).
        for (int i = 0; i < 4; i++) step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MS);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, DEF);
        // Watchdog: five stall cycles then HALT.
        for (int i = 0; i < 5; i++) step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MS);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, HLT);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, HLT);
        step(1, 1, 5'd8, 5'd8, 5'd0, 1, 1, 0, 0, HLT);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, DEF); // reset leaves HALT
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, DEF);
        // Reset during MEM_WAIT.
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MS);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MS);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, DEF);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, DEF);
        step(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, JMP);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage pipeline. Decides every cycle whether each pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) captures, holds, or loads a bubble. It covers three cases: load-use hazards, taken branches and jumps, and multi-cycle data-memory accesses. A watchdog detects a data-memory access that never completes and halts the pipeline.

## Interface
Parameters:
- MEM_WAIT_MAX, default 15: maximum consecutive wait cycles on one data-memory access before timeout; legal range 1..255.

Ports:
- clk  in  1  pipeline clock; state updates on the falling edge, same as the pipeline registers
- reset  in  1  asynchronous, active-low reset
- in_IF_ID_Rs  in  5  rs field of the instruction in ID
- in_IF_ID_Rt  in  5  rt field of the instruction in ID
- in_ID_EX_MemRead  in  1  instruction in EX is a load
- in_ID_EX_Rt  in  5  destination of the load in EX
- in_Jump  in  1  jump decoded in ID
- in_BranchTaken  in  1  branch resolved taken in EX
- in_MemAccess  in  1  load/store in MEM stage
- in_MemReady  in  1  data memory completes the access this cycle
- out_PCWrite  out  1  PC capture enable
- out_IF_ID_Write  out  1  IF/ID capture enable
- out_IF_ID_Flush  out  1  IF/ID loads a NOP
- out_ID_EX_Flush  out  1  ID/EX control bits cleared (bubble)
- out_EX_MEM_Write  out  1  EX/MEM capture enable
- out_MEM_WB_Bubble  out  1  MEM/WB loads CtrlRegWrite=0
- out_MemTimeout  out  1  sticky watchdog flag
- out_StallCount  out  32  present only with HAZARD_STATS_EN
- out_FlushCount  out  32  present only with HAZARD_STATS_EN

## Operation
- FSM states: RUN, MEM_WAIT, HALT.
- **MemStall** = in_MemAccess & ~in_MemReady.
- **LoadUse** = in_ID_EX_MemRead & in_ID_EX_Rt≠0 & (in_ID_EX_Rt==in_IF_ID_Rs | in_ID_EX_Rt==in_IF_ID_Rt).
- Outputs are Mealy decodes, evaluated in priority order (highest first):
  1. **HALT**: all write enables 0, flushes 0, out_MEM_WB_Bubble=1, out_MemTimeout=1.
  2. **MemStall** (RUN or MEM_WAIT): PCWrite=IF_ID_Write=EX_MEM_Write=0, ID_EX_Flush=0 (ID/EX holds via its own stall path), MEM_WB_Bubble=1. Branch, jump and load-use requests are ignored this cycle and are re-evaluated once the stall releases.
  3. **in_BranchTaken**: IF_ID_Flush=1, ID_EX_Flush=1, all enables 1.
  4. **LoadUse**: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, EX_MEM_Write=1.
  5. **in_Jump**: IF_ID_Flush=1, all enables 1.
  6. Default: all enables 1, flushes 0, bubble 0.
- Transitions:
  - RUN→MEM_WAIT on MemStall; the wait counter loads 1.
  - In MEM_WAIT, a MemStall cycle increments the wait counter.
  - MEM_WAIT→RUN when in_MemReady=1 or in_MemAccess=0; the wait counter clears.
  - MEM_WAIT→HALT when the wait counter equals MEM_WAIT_MAX and MemStall is still true.
  - HALT is left only by reset.
- Wait counter width: 8 bits.

## Timing
- Control outputs are combinational from current state and inputs, and are valid before the falling edge that the pipeline registers sample on. There are zero cycles of added latency.
- A load-use stall lasts exactly one cycle: the injected bubble clears in_ID_EX_MemRead.
- A branch flush lasts one cycle per asserted in_BranchTaken cycle.
- Memory wait: freeze lasts exactly N cycles for memory latency N ≤ MEM_WAIT_MAX. If in_MemReady is not seen within MEM_WAIT_MAX+1 stall cycles, the FSM enters HALT.
- Reset values (forced while reset=0, independent of inputs): state RUN, wait counter 0, PCWrite=IF_ID_Write=EX_MEM_Write=1, IF_ID_Flush=ID_EX_Flush=MEM_WB_Bubble=0, out_MemTimeout=0, statistics counters 0.
- Reset mid-wait or in HALT: immediate return to RUN; the in-flight access is abandoned.

## Configuration
- HAZARD_STATS_EN defined:
  - out_StallCount increments on every falling edge with out_PCWrite=0.
  - out_FlushCount increments on every falling edge with out_IF_ID_Flush=1.
  - Both counters saturate at 32'hFFFFFFFF.
- HAZARD_STATS_EN undefined: both ports and their counters are absent, and the remaining behaviour is identical.

## Structure
- pipeline_ctrl_pkg:
  - FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2)
  - ZERO_REG=5'd0
  - wait-counter width constant
- Sub-module load_use_detector: combinational comparator producing LoadUse; it is reused by the forwarding unit.

## Test plan
- Load followed by dependent instruction (ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8) → one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; same case with Rt=0 → no stall.
- BranchTaken=1 together with LoadUse true → IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1.
- MemAccess=1, MemReady low 3 cycles then high → enables 0 and MEM_WB_Bubble=1 for exactly 3 cycles, RUN on 4th.
- MEM_WAIT_MAX=4, MemReady never asserted → out_MemTimeout=1 after 5 stall cycles, all enables stay 0 until reset.
- Reset asserted during MEM_WAIT → outputs immediately at reset values; after release, default decode.
- With HAZARD_STATS_EN: 2 load-use stalls + 3 branch flushes → out_StallCount=2, out_FlushCount=3.
